key_entry_ctrl: RTL and testbench

//  Sequencer between the keypad scanner and the dual seven-segment driver.

---
 rtl/key_entry_pkg.sv | 17 +
 rtl/key_entry_ctrl_db_timer.sv | 45 ++++
 rtl/key_entry_ctrl.sv | 143 ++++++++++++++
 tb/tb_key_entry_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_entry_pkg.sv
// Shared types and helpers for the keypad entry sequencer.
package key_entry_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} key_state_t;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_RESET_CODE = 4'h0;

  // Width needed to count up to the longer of the two timer lengths.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_entry_ctrl_db_timer.sv
// Shared saturating debounce/repeat timer with clear, enable and terminal-count flag.
// The terminal count selects the debounce or repeat length.
module db_timer
  import key_entry_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 120000,
  parameter int unsigned REPEAT_CYCLES = 3000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic rep_sel_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = cnt_width(DB_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == (rep_sel_i ? REP_LAST : DB_LAST));

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad-to-display sequencer: debounces press/release, freezes the scan while held,
// and commits one digit per press. Define KEY_REPEAT_EN for auto-repeat while held.
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 120000,
  parameter int unsigned REPEAT_CYCLES = 3000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic       scan_hold_o,
  output logic [3:0] digit_new_o,
  output logic [3:0] digit_old_o,
  output logic       entry_pulse_o
);

  key_state_t state_q, state_d;
  key_code_t  code_q, code_d;
  key_code_t  new_q, new_d;
  key_code_t  old_q, old_d;
  logic       pulse_q, pulse_d;
  logic       hold_q, hold_d;
  logic       commit;
  logic       tmr_clear, tmr_enable, tmr_rep_sel, tmr_tc;

  db_timer #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_db_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .rep_sel_i(tmr_rep_sel),
    .tc_c_o   (tmr_tc)
  );

`ifdef KEY_REPEAT_EN
  assign tmr_rep_sel = (state_q == HELD);
`else
  assign tmr_rep_sel = 1'b0;
`endif

  // Next-state, timer control and commit decision.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    new_d      = new_q;
    old_d      = old_q;
    pulse_d    = 1'b0;
    commit     = 1'b0;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (key_valid_i) begin
          state_d = PRESS_DB;
          code_d  = key_code_i;
        end
      end
      PRESS_DB: begin
        if (!key_valid_i || (key_code_i != code_q)) begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          state_d   = HELD;
          commit    = 1'b1;
          tmr_clear = 1'b1;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      HELD: begin
        if (!key_valid_i) begin
          state_d   = REL_DB;
          tmr_clear = 1'b1;
        end else begin
`ifdef KEY_REPEAT_EN
          if (tmr_tc) begin
            commit    = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            tmr_enable = 1'b1;
          end
`else
          tmr_clear = 1'b1;
`endif
        end
      end
      REL_DB: begin
        if (key_valid_i) begin
          state_d   = HELD;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tmr_clear = 1'b1;
      end
    endcase

    if (commit) begin
      old_d   = new_q;
      new_d   = code_q;
      pulse_d = 1'b1;
    end

    hold_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      code_q  <= KEY_RESET_CODE;
      new_q   <= KEY_RESET_CODE;
      old_q   <= KEY_RESET_CODE;
      pulse_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      new_q   <= new_d;
      old_q   <= old_d;
      pulse_q <= pulse_d;
      hold_q  <= hold_d;
    end
  end

  assign scan_hold_o   = hold_q;
  assign digit_new_o   = new_q;
  assign digit_old_o   = old_q;
  assign entry_pulse_o = pulse_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed scenarios plus random key activity against a run-length model.
module tb_key_entry_ctrl;

  localparam int unsigned DB  = 8;
  localparam int unsigned REP = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       scan_hold;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       entry_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  key_entry_ctrl #(
    .DB_CYCLES    (DB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .key_valid_i  (key_valid),
    .key_code_i   (key_code),
    .scan_hold_o  (scan_hold),
    .digit_new_o  (digit_new),
    .digit_old_o  (digit_old),
    .entry_pulse_o(entry_pulse)
  );

  always #5 clk = ~clk;

  // Model: a press is accepted after DB+1 consecutive matching samples, released after
  // DB+1 consecutive empty samples; optional repeat every REP valid samples while pressed.
  bit         m_pressed = 1'b0;
  int         cand_len = 0;
  logic [3:0] cand_code = 4'h0;
  int         rel_len = 0;
  int         rep_cnt = 0;
  logic [3:0] m_new = 4'h0;
  logic [3:0] m_old = 4'h0;
  bit         m_pulse = 1'b0;
  bit         m_hold = 1'b0;

  always @(posedge clk) begin
    m_pulse = 1'b0;
    if (reset) begin
      m_pressed = 1'b0; cand_len = 0; rel_len = 0; rep_cnt = 0;
      m_new = 4'h0; m_old = 4'h0;
    end else if (!m_pressed) begin
      if (!key_valid) cand_len = 0;
      else if (cand_len == 0) begin cand_len = 1; cand_code = key_code; end
      else if (key_code != cand_code) cand_len = 0;
      else begin
        cand_len++;
        if (cand_len == int'(DB) + 1) begin
          m_old = m_new; m_new = cand_code; m_pulse = 1'b1;
          m_pressed = 1'b1; cand_len = 0; rel_len = 0; rep_cnt = 0;
        end
      end
    end else begin
      if (!key_valid) begin
        rel_len++; rep_cnt = 0;
        if (rel_len == int'(DB) + 1) begin m_pressed = 1'b0; rel_len = 0; end
      end else if (rel_len > 0) begin
        rel_len = 0; rep_cnt = 0;
      end else begin
`ifdef KEY_REPEAT_EN
        if (rep_cnt == int'(REP) - 1) begin
          m_old = m_new; m_new = cand_code; m_pulse = 1'b1; rep_cnt = 0;
        end else rep_cnt++;
`endif
      end
    end
    m_hold = m_pressed || (cand_len > 0);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("scan_hold", 32'(scan_hold), 32'(m_hold));
      cmp("digit_new", 32'(digit_new), 32'(m_new));
      cmp("digit_old", 32'(digit_old), 32'(m_old));
      cmp("entry_pulse", 32'(entry_pulse), 32'(m_pulse));
      if (entry_pulse === 1'b1) pulse_cnt++;
    end
  end

  task automatic drive(input logic v, input logic [3:0] c, input int n);
    repeat (n) begin
      @(negedge clk);
      key_valid = v;
      key_code  = c;
    end
  endtask

  task automatic settle_pulses(input int base, input int exp, input string name);
    @(negedge clk);
    #1;
    cmp(name, 32'(pulse_cnt - base), 32'(exp));
  endtask

`ifdef KEY_REPEAT_EN
  localparam int T1_PULSES = 2;
  localparam logic [3:0] T1_OLD = 4'h5;
  localparam int T6_PULSES = 4;
  localparam logic [3:0] T6_OLD = 4'h2;
`else
  localparam int T1_PULSES = 1;
  localparam logic [3:0] T1_OLD = 4'h0;
  localparam int T6_PULSES = 1;
  localparam logic [3:0] T6_OLD = 4'h6;
`endif

  initial begin
    int base;
    logic [3:0] c;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    cmp("reset_hold", 32'(scan_hold), 32'h0);
    cmp("reset_new", 32'(digit_new), 32'h0);
    cmp("reset_pulse", 32'(entry_pulse), 32'h0);
    reset = 1'b0;
    drive(0, 4'h0, 3);

    // 1: single press of 5, latency and release tail
    base = pulse_cnt;
    drive(1, 4'h5, 1);
    repeat (8) @(negedge clk);
    cmp("t1_no_early_pulse", 32'(entry_pulse), 32'h0);
    @(negedge clk);
    cmp("t1_pulse_at_8", 32'(entry_pulse), 32'h1);
    cmp("t1_new", 32'(digit_new), 32'h5);
    cmp("t1_old_first", 32'(digit_old), 32'h0);
    drive(1, 4'h5, 20);
    drive(0, 4'h0, 1);
    repeat (8) @(negedge clk);
    cmp("t1_hold_tail", 32'(scan_hold), 32'h1);
    @(negedge clk);
    cmp("t1_hold_drop", 32'(scan_hold), 32'h0);
    drive(0, 4'h0, 3);
    settle_pulses(base, T1_PULSES, "t1_pulses");
    cmp("t1_old", 32'(digit_old), 32'(T1_OLD));

    // 2: glitch
    base = pulse_cnt;
    drive(1, 4'h7, 3);
    drive(0, 4'h0, 12);
    settle_pulses(base, 0, "t2_pulses");
    cmp("t2_new", 32'(digit_new), 32'h5);

    // 3: code change mid-debounce
    base = pulse_cnt;
    drive(1, 4'h3, 4);
    drive(1, 4'h9, 12);
    drive(0, 4'h0, 12);
    settle_pulses(base, 1, "t3_pulses");
    cmp("t3_new", 32'(digit_new), 32'h9);
    cmp("t3_old", 32'(digit_old), 32'h5);

    // 4: press 5 with release bounce, then A
    base = pulse_cnt;
    drive(1, 4'h5, 12);
    drive(0, 4'h5, 3);
    drive(1, 4'h5, 4);
    drive(0, 4'h0, 12);
    drive(1, 4'hA, 12);
    drive(0, 4'h0, 12);
    settle_pulses(base, 2, "t4_pulses");
    cmp("t4_new", 32'(digit_new), 32'hA);
    cmp("t4_old", 32'(digit_old), 32'h5);

    // 5: reset during press debounce
    base = pulse_cnt;
    drive(1, 4'h6, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cmp("t5_rst_hold", 32'(scan_hold), 32'h0);
    cmp("t5_rst_new", 32'(digit_new), 32'h0);
    cmp("t5_rst_old", 32'(digit_old), 32'h0);
    reset = 1'b0;
    drive(1, 4'h6, 12);
    drive(0, 4'h0, 12);
    settle_pulses(base, 1, "t5_pulses");
    cmp("t5_new", 32'(digit_new), 32'h6);

    // 6: long hold of 2
    base = pulse_cnt;
    drive(1, 4'h2, 70);
    drive(0, 4'h0, 12);
    settle_pulses(base, T6_PULSES, "t6_pulses");
    cmp("t6_new", 32'(digit_new), 32'h2);
    cmp("t6_old", 32'(digit_old), 32'(T6_OLD));

    // Random key activity
    for (int ep = 0; ep < 120; ep++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 9));
      c = 4'($urandom_range(0, 15));
      if (r == 0) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else if (r < 4) begin
        drive(1, c, int'($urandom_range(1, 10)));
      end else begin
        len = int'($urandom_range(5, 60));
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 7) == 0) drive(1, 4'($urandom_range(0, 15)), 1);
          else if ($urandom_range(0, 15) == 0) drive(0, c, int'($urandom_range(1, 10)));
          else drive(1, c, 1);
        end
      end
      drive(0, 4'($urandom_range(0, 15)), int'($urandom_range(1, 14)));
    end

    drive(0, 4'h0, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
